// File: rtl/serial_frame_receiver_pkg.sv
// Shared types, defaults and header matching for the serial frame receiver.
// Optional checksum support is enabled with SERIAL_FRAME_RX_CHECKSUM_EN.
package serial_frame_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_e;

  localparam int unsigned DEF_PAYLOAD_BYTES  = 16;
  localparam int unsigned DEF_NUM_CHANNELS   = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1_000_000;

  // Difference is taken mod 256 so bases near 8'hFF wrap.
  function automatic logic header_match(
    input logic [7:0]  b,
    input logic [7:0]  base,
    input int unsigned n
  );
    logic [7:0] d;
    d = b - base;
    return {24'd0, d} < n;
  endfunction

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Byte stream in, payload stream and ready flags out.
// Shared by the UART side (master) and the receiver (slave).
interface serial_frame_receiver_if #(
  parameter int unsigned NUM_CHANNELS = 4
);
  localparam int unsigned CH_W =
    (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [7:0]              rx_byte;
  logic                    new_rx_byte;
  logic [NUM_CHANNELS-1:0] ready_ack;
  logic [7:0]              payload_byte;
  logic                    payload_shift;
  logic [CH_W-1:0]         payload_channel;
  logic [NUM_CHANNELS-1:0] frame_ready;

  modport master (
    output rx_byte, new_rx_byte, ready_ack,
    input  payload_byte, payload_shift,
    input  payload_channel, frame_ready
  );

  modport slave (
    input  rx_byte, new_rx_byte, ready_ack,
    output payload_byte, payload_shift,
    output payload_channel, frame_ready
  );

endinterface

// File: rtl/serial_frame_receiver_timeout.sv
// Inter-byte idle watchdog; fires on the last idle cycle allowed.
// Used by serial_frame_receiver (SERIAL_FRAME_RX_CHECKSUM_EN agnostic).
module serial_frame_rx_timeout
  import serial_frame_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic timed_out_o
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt;

  // A strobe in the expiry cycle wins over the timeout.
  assign timed_out_o = enable_i && !clear_i &&
                       (cnt == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clear_i || !enable_i || timed_out_o)
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// Multi-channel frame receiver: header, payload, optional XOR checksum.
// Define SERIAL_FRAME_RX_CHECKSUM_EN to enable the trailing checksum byte.
module serial_frame_receiver
  import serial_frame_rx_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES  = DEF_PAYLOAD_BYTES,
  parameter int unsigned NUM_CHANNELS   = DEF_NUM_CHANNELS,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] header_base_i,
  serial_frame_receiver_if.slave bus,
  output logic       busy_o,
  output logic       timeout_o,
  output logic       checksum_err_o
);

  localparam int unsigned CH_W =
    (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] PAYLOAD = ST_PAYLOAD;
`ifdef SERIAL_FRAME_RX_CHECKSUM_EN
  localparam logic [1:0] CHECK   = ST_CHECK;
`endif

  logic [1:0]              state;
  logic [CH_W-1:0]         ch;
  logic [CH_W-1:0]         hdr_ch;
  logic [7:0]              cnt;
  logic [7:0]              pbyte;
  logic                    shift;
  logic [NUM_CHANNELS-1:0] ready;
  logic [NUM_CHANNELS-1:0] set_vec;
  logic [NUM_CHANNELS-1:0] clr_vec;
  logic                    tmo_q;
  logic                    timed_out;
  logic                    strobe;
  logic                    accept;
  logic                    last;
  logic                    done;

  assign strobe = bus.new_rx_byte;
  assign hdr_ch = CH_W'(bus.rx_byte - header_base_i);
  assign accept = (state == IDLE) && strobe &&
    header_match(bus.rx_byte, header_base_i, NUM_CHANNELS);
  assign last   = (state == PAYLOAD) && strobe &&
    (cnt == 8'(PAYLOAD_BYTES - 1));

`ifdef SERIAL_FRAME_RX_CHECKSUM_EN
  logic [7:0] csum;
  logic       in_check;
  logic       cerr_q;

  assign in_check = (state == CHECK) && strobe;
  assign done     = in_check && (bus.rx_byte == csum);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      csum   <= '0;
      cerr_q <= 1'b0;
    end else begin
      cerr_q <= in_check && (bus.rx_byte != csum);
      if (accept)
        csum <= '0;
      else if ((state == PAYLOAD) && strobe)
        csum <= csum ^ bus.rx_byte;
    end
  end

  assign checksum_err_o = cerr_q;
`else
  assign done           = last;
  assign checksum_err_o = 1'b0;
`endif

  // A new header clears its channel; a completion beats an ack.
  always_comb begin
    clr_vec = bus.ready_ack;
    set_vec = '0;
    if (accept)
      clr_vec = clr_vec | (NUM_CHANNELS'(1) << hdr_ch);
    if (done)
      set_vec = NUM_CHANNELS'(1) << ch;
  end

  serial_frame_rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clear_i    (strobe),
    .enable_i   (state != IDLE),
    .timed_out_o(timed_out)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      ch    <= '0;
      cnt   <= '0;
      pbyte <= '0;
      shift <= 1'b0;
      ready <= '0;
      tmo_q <= 1'b0;
    end else begin
      shift <= 1'b0;
      tmo_q <= 1'b0;
      ready <= (ready & ~clr_vec) | set_vec;
      unique case (state)
        IDLE: begin
          if (accept) begin
            ch    <= hdr_ch;
            cnt   <= '0;
            state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (strobe) begin
            pbyte <= bus.rx_byte;
            shift <= 1'b1;
            cnt   <= cnt + 8'd1;
`ifdef SERIAL_FRAME_RX_CHECKSUM_EN
            if (last) state <= CHECK;
`else
            if (last) state <= IDLE;
`endif
          end else if (timed_out) begin
            state <= IDLE;
            tmo_q <= 1'b1;
          end
        end
`ifdef SERIAL_FRAME_RX_CHECKSUM_EN
        CHECK: begin
          if (strobe) begin
            state <= IDLE;
          end else if (timed_out) begin
            state <= IDLE;
            tmo_q <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.payload_byte    = pbyte;
  assign bus.payload_shift   = shift;
  assign bus.payload_channel = ch;
  assign bus.frame_ready     = ready;
  assign busy_o              = (state != IDLE);
  assign timeout_o           = tmo_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed table-driven bench for serial_frame_receiver.
// Checksum sequences run when SERIAL_FRAME_RX_CHECKSUM_EN is defined.
module tb_serial_frame_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] header_base = 8'hA0;
  logic       busy;
  logic       timeout;
  logic       cerr;

  int nvec = 0;
  int nerr = 0;

  serial_frame_receiver_if #(.NUM_CHANNELS(4)) bus ();

  serial_frame_receiver #(
    .PAYLOAD_BYTES (4),
    .NUM_CHANNELS  (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .header_base_i (header_base),
    .bus           (bus.slave),
    .busy_o        (busy),
    .timeout_o     (timeout),
    .checksum_err_o(cerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       stb;
    logic [7:0] rx;
    logic [3:0] ack;
    logic [7:0] base;
    logic       shift;
    logic [7:0] pbyte;
    logic [1:0] ch;
    logic [3:0] rdy;
    logic       busy;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(
    input logic s, input logic [7:0] r,
    input logic [3:0] a, input logic [7:0] b,
    input logic sh, input logic [7:0] pb,
    input logic [1:0] c, input logic [3:0] rd,
    input logic bz
  );
    vec_t v;
    v.stb = s; v.rx = r; v.ack = a; v.base = b;
    v.shift = sh; v.pbyte = pb; v.ch = c;
    v.rdy = rd; v.busy = bz;
    return v;
  endfunction

  function automatic logic [17:0] outs();
    return {bus.payload_shift, bus.payload_byte,
            bus.payload_channel, bus.frame_ready,
            busy, timeout, cerr};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic s, input logic [7:0] r,
                       input logic [3:0] a);
    @(negedge clk);
    bus.new_rx_byte = s;
    bus.rx_byte     = r;
    bus.ready_ack   = a;
    @(posedge clk);
    #1;
    bus.new_rx_byte = 1'b0;
    bus.ready_ack   = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_outputs", 32'(outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.new_rx_byte = 1'b0;
    bus.rx_byte     = '0;
    bus.ready_ack   = '0;

    tbl[0]  = mk(1, 8'hA2, 0, 8'hA0, 0, 8'h00, 2, 4'b0000, 1);
    tbl[1]  = mk(1, 8'h11, 0, 8'hA0, 1, 8'h11, 2, 4'b0000, 1);
    tbl[2]  = mk(1, 8'h22, 0, 8'hA0, 1, 8'h22, 2, 4'b0000, 1);
    tbl[3]  = mk(1, 8'h33, 0, 8'hA0, 1, 8'h33, 2, 4'b0000, 1);
    tbl[4]  = mk(1, 8'h44, 0, 8'hA0, 1, 8'h44, 2, 4'b0100, 0);
    tbl[5]  = mk(0, 8'h00, 4'b0100, 8'hA0,
                 0, 8'h44, 2, 4'b0000, 0);
    tbl[6]  = mk(1, 8'h02, 0, 8'hFE, 0, 8'h44, 2, 4'b0000, 0);
    tbl[7]  = mk(1, 8'h7F, 0, 8'hFE, 0, 8'h44, 2, 4'b0000, 0);
    tbl[8]  = mk(1, 8'h01, 0, 8'hFE, 0, 8'h44, 3, 4'b0000, 1);
    tbl[9]  = mk(1, 8'h10, 0, 8'hFE, 1, 8'h10, 3, 4'b0000, 1);
    tbl[10] = mk(1, 8'h20, 0, 8'hFE, 1, 8'h20, 3, 4'b0000, 1);
    tbl[11] = mk(1, 8'h30, 0, 8'hFE, 1, 8'h30, 3, 4'b0000, 1);
    tbl[12] = mk(1, 8'h40, 0, 8'hFE, 1, 8'h40, 3, 4'b1000, 0);
    tbl[13] = mk(0, 8'h00, 0, 8'hFE, 0, 8'h40, 3, 4'b1000, 0);
    tbl[14] = mk(1, 8'hFF, 0, 8'hFE, 0, 8'h40, 1, 4'b1000, 1);
    tbl[15] = mk(1, 8'h05, 0, 8'hFE, 1, 8'h05, 1, 4'b1000, 1);
    tbl[16] = mk(1, 8'h06, 0, 8'hFE, 1, 8'h06, 1, 4'b1000, 1);
    tbl[17] = mk(1, 8'h07, 0, 8'hFE, 1, 8'h07, 1, 4'b1000, 1);
    tbl[18] = mk(1, 8'h08, 4'b1010, 8'hFE,
                 1, 8'h08, 1, 4'b0010, 0);
    tbl[19] = mk(1, 8'hFE, 0, 8'hFE, 0, 8'h08, 0, 4'b0010, 1);
    tbl[20] = mk(1, 8'h01, 0, 8'hFE, 1, 8'h01, 0, 4'b0010, 1);
    tbl[21] = mk(1, 8'h02, 0, 8'hFE, 1, 8'h02, 0, 4'b0010, 1);
    tbl[22] = mk(1, 8'h03, 0, 8'hFE, 1, 8'h03, 0, 4'b0010, 1);
    tbl[23] = mk(1, 8'h04, 0, 8'hFE, 1, 8'h04, 0, 4'b0011, 0);
    tbl[24] = mk(1, 8'hFE, 0, 8'hFE, 0, 8'h04, 0, 4'b0010, 1);
    tbl[25] = mk(1, 8'h09, 0, 8'hFE, 1, 8'h09, 0, 4'b0010, 1);
    tbl[26] = mk(1, 8'h0A, 0, 8'hFE, 1, 8'h0A, 0, 4'b0010, 1);
    tbl[27] = mk(1, 8'h0B, 0, 8'hFE, 1, 8'h0B, 0, 4'b0010, 1);
    tbl[28] = mk(1, 8'h0C, 0, 8'hFE, 1, 8'h0C, 0, 4'b0011, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef SERIAL_FRAME_RX_CHECKSUM_EN
    header_base = 8'hA0;
    apply(1, 8'hA0, 0);
    apply(1, 8'h01, 0);
    apply(1, 8'h02, 0);
    apply(1, 8'h04, 0);
    apply(1, 8'h08, 0);
    chk("csum_wait_busy", 32'(busy), 32'd1);
    chk("csum_wait_ready", 32'(bus.frame_ready), 32'd0);
    apply(1, 8'h0F, 0);
    chk("csum_ok_ready", 32'(bus.frame_ready), 32'b0001);
    chk("csum_ok_noshift", 32'(bus.payload_shift), 32'd0);
    chk("csum_ok_noerr", 32'(cerr), 32'd0);
    chk("csum_ok_idle", 32'(busy), 32'd0);
    apply(1, 8'hA0, 0);
    chk("csum_hdr_clear", 32'(bus.frame_ready), 32'd0);
    apply(1, 8'h01, 0);
    apply(1, 8'h02, 0);
    apply(1, 8'h04, 0);
    apply(1, 8'h08, 0);
    apply(1, 8'h0E, 0);
    chk("csum_bad_err", 32'(cerr), 32'd1);
    chk("csum_bad_ready", 32'(bus.frame_ready), 32'd0);
    apply(0, 8'h00, 0);
    chk("csum_err_pulse", 32'(cerr), 32'd0);
`else
    for (int i = 0; i < 29; i++) begin
      logic [17:0] exp;
      header_base = tbl[i].base;
      apply(tbl[i].stb, tbl[i].rx, tbl[i].ack);
      exp = {tbl[i].shift, tbl[i].pbyte, tbl[i].ch,
             tbl[i].rdy, tbl[i].busy, 1'b0, 1'b0};
      if (outs() !== exp) begin
        nerr++;
        $display("FAIL vec%0d: got %05h expected %05h",
                 i, outs(), exp);
      end
      nvec++;
    end
`endif

    do_reset();
    header_base = 8'hFE;

    apply(1, 8'hFF, 0);
    apply(1, 8'h01, 0);
    apply(1, 8'h02, 0);
    for (int i = 1; i <= 8; i++) begin
      apply(0, 8'h00, 0);
      chk($sformatf("timeout_pulse_%0d", i),
          32'(timeout), 32'(i == 8));
      chk($sformatf("timeout_busy_%0d", i),
          32'(busy), 32'(i != 8));
    end
    apply(0, 8'h00, 0);
    chk("timeout_once", 32'(timeout), 32'd0);
    chk("timeout_ready", 32'(bus.frame_ready), 32'd0);

    apply(1, 8'h00, 0);
    apply(1, 8'h01, 0);
    apply(1, 8'h02, 0);
    apply(1, 8'h03, 0);
    apply(1, 8'h04, 0);
`ifdef SERIAL_FRAME_RX_CHECKSUM_EN
    apply(1, 8'h04, 0);
`endif
    chk("after_timeout_ready", 32'(bus.frame_ready), 32'b0100);

    apply(1, 8'hFF, 0);
    apply(1, 8'h01, 0);
    repeat (7) apply(0, 8'h00, 0);
    apply(1, 8'h02, 0);
    chk("expiry_strobe_to", 32'(timeout), 32'd0);
    chk("expiry_strobe_shift", 32'(bus.payload_shift), 32'd1);
    chk("expiry_strobe_busy", 32'(busy), 32'd1);
    apply(1, 8'h03, 0);
    apply(1, 8'h04, 0);
`ifdef SERIAL_FRAME_RX_CHECKSUM_EN
    apply(1, 8'h04, 0);
`endif
    chk("expiry_frame_ready", 32'(bus.frame_ready), 32'b0110);

    apply(1, 8'h00, 0);
    chk("midframe_hdr_clear", 32'(bus.frame_ready), 32'b0010);
    apply(1, 8'h05, 0);
    do_reset();
    apply(0, 8'h00, 0);
    chk("post_reset_idle", 32'(outs()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Parametrised multi-channel frame receiver for the host serial link. It sits between the UART byte receiver and the per-core nonce shift registers. It accepts frames made of one header byte, a configurable number of payload bytes and an optional trailing checksum. The header byte selects one of several destination channels. Each channel has a sticky ready flag, held until that channel's consumer acknowledges it.

## Interface
- PAYLOAD_BYTES, 16: payload bytes per frame; legal range 1..255.
- NUM_CHANNELS, 4: destination channels; legal range 1..16.
- TIMEOUT_CYCLES, 1_000_000: idle clock cycles allowed between bytes inside a frame before the frame is abandoned; must be ≥1.
- clk_i  in  1  system clock; single clock domain.
- rst_n_i  in  1  synchronous, active-low reset.
- header_base_i  in  8  header value for channel 0; channel c uses header_base_i + c.
- rx_byte_i  in  8  byte from the UART receiver.
- new_rx_byte_i  in  1  one-cycle strobe; rx_byte_i is valid in that cycle.
- ready_ack_i  in  NUM_CHANNELS  per-channel acknowledge; clears the matching ready bit.
- payload_byte_o  out  8  registered copy of the accepted payload byte.
- payload_shift_o  out  1  one-cycle pulse; payload_byte_o is valid.
- payload_channel_o  out  $clog2(NUM_CHANNELS) (min 1)  channel of the frame in progress; stable from header to frame end.
- frame_ready_o  out  NUM_CHANNELS  sticky per-channel frame-complete flags.
- busy_o  out  1  high whenever the state is not IDLE.
- timeout_o  out  1  one-cycle pulse when a frame is abandoned on timeout.
- checksum_err_o  out  1  one-cycle pulse on a checksum mismatch (checksum builds only; tied 0 otherwise).

## Operation
- Header match: a header matches when (rx_byte_i − header_base_i) mod 256 < NUM_CHANNELS. The difference is computed in 8 bits.
- States:
  - IDLE: a matching header on a strobe latches the channel, zeroes the byte counter (and the checksum accumulator) and moves to PAYLOAD. Non-matching bytes are ignored.
  - PAYLOAD: each strobe registers the byte and pulses payload_shift_o. The byte counter (8 bits) increments.
  - On the strobe where the counter equals PAYLOAD_BYTES−1:
    - without checksum, set frame_ready_o[ch] and go to IDLE;
    - with checksum, go to CHECK.
  - CHECK (checksum builds only): the next strobe is compared with the accumulator. On a match, set frame_ready_o[ch]. On a mismatch, pulse checksum_err_o. Either way, go to IDLE. The checksum byte is never shifted out.
- Header acceptance for channel c clears frame_ready_o[c], because the consumer's shift register is about to be overwritten.
- ready_ack_i[c] clears frame_ready_o[c]. If a set and an ack for the same channel occur in the same cycle, the set wins.
- Timeout:
  - The counter resets on every strobe and counts while not in IDLE.
  - When it reaches TIMEOUT_CYCLES: return to IDLE, pulse timeout_o, leave all ready bits unchanged.
  - Bytes already shifted out are stale; consumers must gate on frame_ready_o.
- Reset while mid-frame: return to IDLE immediately and discard the frame without any error pulse.

## Timing
- Reset values: state IDLE; payload_byte_o 0, payload_shift_o 0, payload_channel_o 0, frame_ready_o 0, busy_o 0, timeout_o 0, checksum_err_o 0; all counters 0.
- Latency:
  - Strobe in cycle N gives payload_shift_o and payload_byte_o in cycle N+1.
  - On the final payload byte (or the checksum byte), the frame_ready_o bit rises in N+1.
  - busy_o rises in N+1 after the header strobe.
- Back-to-back strobes in consecutive cycles are supported.
- A strobe in the same cycle as the timeout expiry counts as a byte, not a timeout.
- The header of the next frame can arrive in the cycle immediately after the frame-ending strobe.
- payload_channel_o holds its last value while in IDLE.

## Configuration
- SERIAL_FRAME_RX_CHECKSUM_EN defined:
  - The frame carries a trailing byte equal to the XOR of all payload bytes, and the CHECK state exists.
  - A mismatch discards the frame, pulses checksum_err_o and leaves frame_ready_o unchanged, except for the clear applied when the header was accepted.
- Not defined: no CHECK state, no accumulator, checksum_err_o tied to 0, and the frame is PAYLOAD_BYTES+1 bytes long.

## Structure
- Package serial_frame_rx_pkg: state enum (IDLE, PAYLOAD, CHECK); default constants for PAYLOAD_BYTES, NUM_CHANNELS and TIMEOUT_CYCLES; the header-match function.
- Sub-module serial_frame_rx_timeout:
  - ports clk_i, rst_n_i, clear_i, enable_i, timed_out_o;
  - counter width $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Clean frame, PAYLOAD_BYTES=4, header_base_i=8'hA0: bytes A2,11,22,33,44 → four shift pulses with bytes 11,22,33,44, payload_channel_o=2, frame_ready_o=4'b0100 one cycle after the 44 strobe; ready_ack_i[2] then clears it.
- Wrap-around matching: header_base_i=8'hFE, NUM_CHANNELS=4 → byte 01 selects channel 3; bytes 02 and 7F in IDLE are ignored with busy_o staying 0.
- Timeout: TIMEOUT_CYCLES=8; header plus 2 payload bytes, then 8 idle cycles → timeout_o pulses once, state IDLE, frame_ready_o unchanged; a new full frame afterwards completes normally.
- Set/ack collision: frame for channel 1 ends in the same cycle that ready_ack_i[1]=1 → frame_ready_o[1]=1.
- Re-header clear: frame_ready_o[0]=1, then a new channel-0 header → bit clears one cycle after the header strobe.
- Checksum build: payload 01,02,04,08 followed by 0F → ready set; followed by 0E → checksum_err_o pulse, ready stays 0. Assert reset mid-frame → all outputs 0 next cycle.
